hp_addsub_sequencer: RTL and testbench
======================================

Name: hp_addsub_sequencer

Overview:
- Upstream issue/capture stage wrapped around the combinational half-precision add/subtract datapath.
- Accepts operand pairs plus an add/sub opcode over a valid/ready handshake. For subtract, it negates operand b by flipping its sign bit.
- Holds the operands stable on the adder inputs for a programmable settle time, then registers the result, classification flags and exception flags into a valid/ready output register.
- Accumulates sticky exception flags for software.

Parameters:
- NEXP, 5, exponent field width.
- NSIG, 10, significand (fraction) field width; operand width is NEXP+NSIG+1.
- NTYPES, 5, width of the bfFlags classification vector from the adder.
- NEXCEPTIONS, 5, width of the exception vector from the adder.
- LAT, 1, number of EXEC cycles the adder inputs are held before capture; legal range 1..15.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept a request this cycle.
- op  input  1  0 = add, 1 = subtract.
- a  input  NEXP+NSIG+1  operand a.
- b  input  NEXP+NSIG+1  operand b.
- add_a  output  NEXP+NSIG+1  registered operand a, driven to the adder.
- add_b  output  NEXP+NSIG+1  registered operand b (sign-adjusted), driven to the adder.
- add_s  input  NEXP+NSIG+1  adder result.
- add_flags  input  NTYPES  adder bfFlags.
- add_exc  input  NEXCEPTIONS  adder exception.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer accepts the result.
- result  output  NEXP+NSIG+1  captured result.
- bfFlags  output  NTYPES  captured classification flags.
- exception  output  NEXCEPTIONS  captured exception flags.
- sticky_exc  output  NEXCEPTIONS  OR of all captured exception vectors since reset or the last clear.
- clr_sticky  input  1  synchronous clear of sticky_exc.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE and the counter to 0.
  - add_a, add_b, result, bfFlags, exception and sticky_exc all go to 0.
  - out_valid goes to 0.
  - in_ready reads 1 once rst deasserts.
- States: IDLE, EXEC, HOLD.
- in_ready = (state==IDLE) or (state==HOLD and out_ready). It is combinational and is 0 throughout EXEC.
- Accept: on a rising edge with in_valid and in_ready both high:
  - add_a <= a.
  - add_b <= {b[MSB]^op, b[MSB-1:0]}. The sign is flipped for every encoding, including NaN, zero and inf.
  - count <= LAT-1; state <= EXEC.
- EXEC:
  - add_a and add_b are held constant.
  - Each edge with count != 0: count <= count-1.
  - Edge with count == 0: result <= add_s, bfFlags <= add_flags, exception <= add_exc, out_valid <= 1, state <= HOLD.
- Latency: out_valid rises exactly LAT cycles after the accept edge.
- HOLD:
  - result, bfFlags, exception and out_valid are stable until out_ready=1 on an edge.
  - Edge with out_ready and no accept: out_valid <= 0, state <= IDLE. The output registers keep their last values.
  - Edge with out_ready and in_valid (back-to-back): the result is consumed and the new request is accepted on the same edge. out_valid <= 0 and state <= EXEC.
- Operands presented while in_ready=0 are ignored; no buffering.
- sticky_exc:
  - On the capture edge, sticky_exc <= (clr_sticky ? 0 : sticky_exc) | add_exc. If a clear and a capture occur on the same edge, the new capture's bits survive.
  - On a non-capture edge with clr_sticky=1, sticky_exc <= 0.
- Reset mid-EXEC or mid-HOLD: the pending operation is discarded, no output is produced, and all state goes to reset values immediately.
- op only takes effect at the accept edge; later changes on op have no effect.

Test Plan:
- Basic add:
  - Stimulus: LAT=1, a=0x3C00 (1.0), b=0x4000 (2.0), op=0, out_ready=1.
  - Required: add_b=0x4000; out_valid is high 1 cycle after accept with result=0x4200; in_ready returns to 1.
- Subtract sign flip:
  - Stimulus: a=0x4200, b=0x3C00, op=1.
  - Required: add_b=0xBC00 throughout EXEC; result=0x4000 is captured.
- Latency and hold:
  - Stimulus: LAT=3, out_ready=0.
  - Required: out_valid rises exactly 3 cycles after accept. It is held for 5 cycles with in_ready=0 and result unchanged. Raising out_ready drops out_valid on the next edge.
- Back-to-back:
  - Stimulus: LAT=1, in_valid held high with 3 requests, out_ready=1.
  - Required: an accept on every edge where state is HOLD; 3 results in issue order; no request lost.
- Sticky exceptions:
  - Stimulus: add_exc=0b00100 on capture 1 and 0b00001 on capture 2; then clr_sticky on a later idle edge; then clr_sticky coincident with a capture whose add_exc=0b10000.
  - Required: sticky_exc is 0b00101 after capture 2, 0 after the idle clear, and 0b10000 after the coincident clear and capture.
- Async reset:
  - Stimulus: assert rst mid-EXEC, between clock edges.
  - Required: out_valid=0, add_a=add_b=0, sticky_exc=0 immediately. No result appears after release. in_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/hp_addsub_sequencer.sv
// Issue/capture sequencer around a combinational half-precision add/sub.
// Holds operands for LAT cycles, then registers result and flags.
module hp_addsub_sequencer #(
  parameter int NEXP        = 5,
  parameter int NSIG        = 10,
  parameter int NTYPES      = 5,
  parameter int NEXCEPTIONS = 5,
  parameter int LAT         = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [NEXP+NSIG:0]     a,
  input  logic [NEXP+NSIG:0]     b,
  output logic [NEXP+NSIG:0]     add_a,
  output logic [NEXP+NSIG:0]     add_b,
  input  logic [NEXP+NSIG:0]     add_s,
  input  logic [NTYPES-1:0]      add_flags,
  input  logic [NEXCEPTIONS-1:0] add_exc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NEXP+NSIG:0]     result,
  output logic [NTYPES-1:0]      bfFlags,
  output logic [NEXCEPTIONS-1:0] exception,
  output logic [NEXCEPTIONS-1:0] sticky_exc,
  input  logic                   clr_sticky
);

  localparam int W = NEXP + NSIG + 1;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]             r_cnt;
  logic [W-1:0]           r_a;
  logic [W-1:0]           r_b;
  logic [W-1:0]           r_res;
  logic [NTYPES-1:0]      r_flags;
  logic [NEXCEPTIONS-1:0] r_exc;
  logic [NEXCEPTIONS-1:0] r_sticky;
  logic                   r_ovalid;

  logic w_accept;
  logic w_capture;
  logic w_consume;

  assign w_accept  = in_valid & in_ready;
  assign w_capture = (r_state == S_EXEC) && (r_cnt == 4'd0);
  assign w_consume = (r_state == S_HOLD) && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: accept enters EXEC, capture enters HOLD, consume exits
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_EXEC;
      S_EXEC: if (w_capture) w_next = S_HOLD;
      S_HOLD: begin
        if (w_accept)       w_next = S_EXEC;
        else if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake output: ready when idle or when the held result drains now
  always_comb begin
    in_ready = 1'b0;
    unique case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_HOLD:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Operand capture and settle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= {b[W-1] ^ op, b[W-2:0]};
      r_cnt <= CNT_INIT;
    end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Result register and its valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res    <= '0;
      r_flags  <= '0;
      r_exc    <= '0;
      r_ovalid <= 1'b0;
    end else if (w_capture) begin
      r_res    <= add_s;
      r_flags  <= add_flags;
      r_exc    <= add_exc;
      r_ovalid <= 1'b1;
    end else if (w_consume) begin
      r_ovalid <= 1'b0;
    end
  end

  // Sticky exceptions; a capture's bits survive a coincident clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_sticky <= '0;
    else if (w_capture)
      r_sticky <= (clr_sticky ? '0 : r_sticky) | add_exc;
    else if (clr_sticky)
      r_sticky <= '0;
  end

  assign add_a      = r_a;
  assign add_b      = r_b;
  assign result     = r_res;
  assign bfFlags    = r_flags;
  assign exception  = r_exc;
  assign sticky_exc = r_sticky;
  assign out_valid  = r_ovalid;

endmodule

// File: tb/tb_hp_addsub_sequencer.sv
// Bench for hp_addsub_sequencer: LAT=1 and LAT=3 instances, a stand-in
// adder, a transaction-level model and directed literal checks.
module tb_hp_addsub_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        iv[2];
  logic        ir[2];
  logic        op_[2];
  logic [15:0] a_[2];
  logic [15:0] b_[2];
  logic [15:0] aa[2];
  logic [15:0] ab[2];
  logic [15:0] s_[2];
  logic [4:0]  fl_in[2];
  logic [4:0]  exc_in[2];
  logic        ov[2];
  logic        ordy[2];
  logic [15:0] res[2];
  logic [4:0]  fl[2];
  logic [4:0]  exc[2];
  logic [4:0]  st[2];
  logic        clr[2];

  int n_chk = 0;
  int n_err = 0;

  // Stand-in adder: two real FP16 sums, bit-sum elsewhere
  function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
    if (x == 16'h3C00 && y == 16'h4000) return 16'h4200;
    if (x == 16'h4200 && y == 16'hBC00) return 16'h4000;
    return x + y;
  endfunction

  function automatic logic [4:0] fflags(input logic [15:0] x, input logic [15:0] y);
    return x[15:11] ^ y[4:0];
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  assign s_[0]    = fadd(aa[0], ab[0]);
  assign s_[1]    = fadd(aa[1], ab[1]);
  assign fl_in[0] = fflags(aa[0], ab[0]);
  assign fl_in[1] = fflags(aa[1], ab[1]);

  hp_addsub_sequencer #(.LAT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .op(op_[0]),
    .a(a_[0]), .b(b_[0]), .add_a(aa[0]), .add_b(ab[0]), .add_s(s_[0]),
    .add_flags(fl_in[0]), .add_exc(exc_in[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .result(res[0]), .bfFlags(fl[0]),
    .exception(exc[0]), .sticky_exc(st[0]), .clr_sticky(clr[0])
  );

  hp_addsub_sequencer #(.LAT(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .op(op_[1]),
    .a(a_[1]), .b(b_[1]), .add_a(aa[1]), .add_b(ab[1]), .add_s(s_[1]),
    .add_flags(fl_in[1]), .add_exc(exc_in[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .result(res[1]), .bfFlags(fl[1]),
    .exception(exc[1]), .sticky_exc(st[1]), .clr_sticky(clr[1])
  );

  // Transaction model: one op in flight, result due LAT edges after accept
  logic        m_busy[2];
  int          m_left[2];
  logic [15:0] m_aa[2];
  logic [15:0] m_ab[2];
  logic        m_ov[2];
  logic [15:0] m_res[2];
  logic [4:0]  m_fl[2];
  logic [4:0]  m_exc[2];
  logic [4:0]  m_st[2];
  logic        m_ir[2];

  always_comb begin
    for (int k = 0; k < 2; k++)
      m_ir[k] = !m_busy[k] && (!m_ov[k] || ordy[k]);
  end

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] <= 1'b0;
        m_left[k] <= 0;
        m_aa[k]   <= '0;
        m_ab[k]   <= '0;
        m_ov[k]   <= 1'b0;
        m_res[k]  <= '0;
        m_fl[k]   <= '0;
        m_exc[k]  <= '0;
        m_st[k]   <= '0;
      end else if (m_busy[k]) begin
        if (m_left[k] == 1) begin
          m_busy[k] <= 1'b0;
          m_ov[k]   <= 1'b1;
          m_res[k]  <= fadd(m_aa[k], m_ab[k]);
          m_fl[k]   <= fflags(m_aa[k], m_ab[k]);
          m_exc[k]  <= exc_in[k];
          m_st[k]   <= (clr[k] ? 5'd0 : m_st[k]) | exc_in[k];
        end else begin
          m_left[k] <= m_left[k] - 1;
          if (clr[k]) m_st[k] <= '0;
        end
      end else begin
        if (clr[k]) m_st[k] <= '0;
        if (m_ov[k] && ordy[k]) m_ov[k] <= 1'b0;
        if (iv[k] && m_ir[k]) begin
          m_aa[k]   <= a_[k];
          m_ab[k]   <= {b_[k][15] ^ op_[k], b_[k][14:0]};
          m_busy[k] <= 1'b1;
          m_left[k] <= lat_of(k);
        end
      end
    end
  end

  task automatic chk(input string nm, input int k,
                     input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got=%h exp=%h t=%0t", nm, k, got, exp, $time);
    end
  endtask

  // Cycle compare against the model
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("in_ready", k, 16'(ir[k]), 16'(m_ir[k]));
        chk("out_valid", k, 16'(ov[k]), 16'(m_ov[k]));
        chk("sticky", k, 16'(st[k]), 16'(m_st[k]));
        if (m_ov[k]) begin
          chk("result", k, res[k], m_res[k]);
          chk("bfFlags", k, 16'(fl[k]), 16'(m_fl[k]));
          chk("exception", k, 16'(exc[k]), 16'(m_exc[k]));
        end
        if (m_busy[k]) begin
          chk("add_a", k, aa[k], m_aa[k]);
          chk("add_b", k, ab[k], m_ab[k]);
        end
      end
    end
  end

  logic [15:0] got_q[$];
  logic        collect = 1'b0;

  always @(negedge clk) begin
    if (collect && ov[0] && ordy[0]) got_q.push_back(res[0]);
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int k, input logic [15:0] x, input logic [15:0] y,
                       input logic o, output int edges);
    logic acc;
    a_[k]  = x;
    b_[k]  = y;
    op_[k] = o;
    iv[k]  = 1'b1;
    edges  = 0;
    do begin
      acc = ir[k];
      step();
      edges++;
    end while (!acc && edges < 20);
    iv[k] = 1'b0;
    chk("accept_timeout", k, 16'(acc), 16'd1);
  endtask

  task automatic wait_ov(input int k, output int n);
    n = 0;
    while (!ov[k] && n < 20) begin
      step();
      n++;
    end
    chk("valid_timeout", k, 16'(ov[k]), 16'd1);
  endtask

  initial begin
    int e;
    int n;
    int tot;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; op_[k] = 1'b0; a_[k] = '0; b_[k] = '0;
      ordy[k] = 1'b1; clr[k] = 1'b0; exc_in[k] = '0;
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 0, 16'(ov[0]), 16'd0);
    chk("rst_add_a", 0, aa[0], 16'h0000);
    chk("rst_result", 1, res[1], 16'h0000);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 0, 16'(ir[0]), 16'd1);
    step();

    // Basic add, LAT=1
    issue(0, 16'h3C00, 16'h4000, 1'b0, e);
    chk("add_b_add", 0, ab[0], 16'h4000);
    step();
    chk("add_valid", 0, 16'(ov[0]), 16'd1);
    chk("add_result", 0, res[0], 16'h4200);
    chk("add_ready", 0, 16'(ir[0]), 16'd1);

    // Subtract: sign flip, late op change ignored
    issue(0, 16'h4200, 16'h3C00, 1'b1, e);
    op_[0] = 1'b0;
    chk("sub_add_b", 0, ab[0], 16'hBC00);
    step();
    chk("sub_result", 0, res[0], 16'h4000);
    step();
    chk("sub_drained", 0, 16'(ov[0]), 16'd0);

    // Latency and hold, LAT=3
    ordy[1] = 1'b0;
    exc_in[1] = 5'b00010;
    issue(1, 16'h3C00, 16'h4000, 1'b0, e);
    wait_ov(1, n);
    chk("latency", 1, 16'(n), 16'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 1, 16'(ov[1]), 16'd1);
      chk("hold_ready", 1, 16'(ir[1]), 16'd0);
      chk("hold_result", 1, res[1], 16'h4200);
    end
    ordy[1] = 1'b1;
    step();
    chk("hold_release", 1, 16'(ov[1]), 16'd0);

    // Back-to-back, LAT=1
    collect = 1'b1;
    tot = 0;
    issue(0, 16'h0001, 16'h0002, 1'b0, e); tot += e;
    issue(0, 16'h0010, 16'h0020, 1'b0, e); tot += e;
    issue(0, 16'h0100, 16'h0200, 1'b0, e); tot += e;
    step();
    step();
    collect = 1'b0;
    chk("b2b_edges", 0, 16'(tot), 16'd5);
    chk("b2b_count", 0, 16'(got_q.size()), 16'd3);
    if (got_q.size() == 3) begin
      chk("b2b_r0", 0, got_q[0], 16'h0003);
      chk("b2b_r1", 0, got_q[1], 16'h0030);
      chk("b2b_r2", 0, got_q[2], 16'h0300);
    end

    // Sticky exceptions
    exc_in[0] = 5'b00100;
    issue(0, 16'h0001, 16'h0001, 1'b0, e);
    wait_ov(0, n);
    exc_in[0] = 5'b00001;
    issue(0, 16'h0002, 16'h0002, 1'b0, e);
    wait_ov(0, n);
    chk("sticky_acc", 0, 16'(st[0]), 16'h0005);
    step();
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("sticky_clr", 0, 16'(st[0]), 16'h0000);
    exc_in[0] = 5'b10000;
    issue(0, 16'h0003, 16'h0003, 1'b0, e);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("sticky_coinc", 0, 16'(st[0]), 16'h0010);
    chk("exc_coinc", 0, 16'(exc[0]), 16'h0010);
    step();

    // Async reset mid-EXEC on the LAT=3 instance
    chk("pre_rst_sticky", 1, 16'(st[1]), 16'h0002);
    issue(1, 16'h1234, 16'h0101, 1'b1, e);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 1, 16'(ov[1]), 16'd0);
    chk("arst_add_a", 1, aa[1], 16'h0000);
    chk("arst_add_b", 1, ab[1], 16'h0000);
    chk("arst_sticky", 1, 16'(st[1]), 16'h0000);
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", 1, 16'(ir[1]), 16'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("arst_no_result", 1, 16'(ov[1]), 16'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
